axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI3-style responder (slave) that serves INCR burst reads and writes from a single-port synchronous SRAM.
- Sits opposite the cache-side AXI bridge. In simulation and SoC bring-up it stands in for main memory, accepting the bridge's ar/r/aw/w/b traffic: i-cache reads carry arid 0 and d-cache reads carry arid 1.
- Handles one transaction at a time. Reads and writes are arbitrated fairly.

Parameters:
- ADDR_WIDTH, 16: SRAM word-address width; depth is 2**ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address that maps to SRAM word 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address channel.
- arvalid  in  1; arready  out  1.
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data channel; rready  in  1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address channel.
- awvalid  in  1; awready  out  1.
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data channel; wready  out  1.
- bid/bresp/bvalid  out  4/2/1  write response channel; bready  in  1.
- sram_en  out  1  SRAM access enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  ADDR_WIDTH  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data; valid the cycle after sram_en=1 with sram_we=0.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; every output 0 (arready, awready, wready, rvalid, bvalid, sram_en, sram_we, rid, bid, rresp, bresp, rlast, rdata); priority flag = read-first. Any in-flight transaction is dropped with no response.
- States: IDLE, RD_BURST, WR_DATA, WR_RESP.
- IDLE:
  - arready = arvalid & (~awvalid | prio_rd); awready = awvalid & (~arvalid | ~prio_rd). These are combinational from the state register.
  - Exactly one handshake can occur per cycle.
  - On an AR handshake: latch arid, word address = (araddr-BASE_ADDR)>>2, beat count = arlen+1. Set prio_rd=0, go to RD_BURST.
  - On an AW handshake: latch awid and address/count the same way. Set prio_rd=1, go to WR_DATA.
- Burst type and size:
  - All burst types are treated as INCR.
  - The word address increments by 1 per beat whatever arsize/awsize is; narrow writes rely on wstrb.
  - The word address wraps modulo 2**ADDR_WIDTH.
- RD_BURST:
  - Issue an SRAM read (sram_en=1, sram_we=0) when beats remain to issue and output capacity exists. Capacity means the output register plus a 1-entry skid buffer cannot overflow given the at most one read in flight.
  - Returning data fills the output register if it is empty or being drained, otherwise the skid buffer.
  - rvalid is registered. rid = latched id. rlast=1 on the final beat only.
  - Latency: first rvalid 2 cycles after the AR handshake. With rready held at 1, one beat per cycle, so a len-N burst finishes N+2 cycles after AR.
  - rready=0 stalls: rdata/rlast/rvalid are held stable and no beat is lost or duplicated.
  - After the rlast handshake go to IDLE; arready may assert that same cycle+1.
- WR_DATA:
  - wready=1.
  - Each W handshake drives sram_en=1, sram_we=wstrb, sram_wdata=wdata at the current address in the same cycle, then increments the address.
  - Termination is by beat count, not wlast. wlast arriving early or late does not change the count.
  - After the final beat go to WR_RESP.
- WR_RESP:
  - bvalid=1, bid = latched awid, bresp=2'b00. Hold until bready, then go to IDLE.
- Simultaneous arvalid and awvalid in IDLE: grant alternates; the side not granted waits with its valid held.
- wvalid may arrive before its AW. It is not accepted (wready=0) until WR_DATA.

Optional Feature:
- Macro AXI_SRAM_RANGE_CHECK_EN.
- Defined: any beat whose byte address lies outside [BASE_ADDR, BASE_ADDR+4*2**ADDR_WIDTH):
  - Read beat: rresp=2'b10 (SLVERR), rdata=0, no SRAM access.
  - Write beat: sram_we suppressed for that beat and the burst's bresp becomes 2'b10.
  - The burst still completes its full beat count.
- Undefined: the address wraps modulo depth and rresp/bresp are always 2'b00.

Decomposition:
- Package axi_slv_pkg holds:
  - the state enum (IDLE, RD_BURST, WR_DATA, WR_RESP);
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - burst constant BURST_INCR=2'b01.
- One sub-module, axi_rd_skid: 1-entry skid buffer between the SRAM read data and the r channel, carrying data, last, resp and valid/ready.

Test Plan:
- Single read: SRAM word 0x10 = 32'hDEADBEEF; AR araddr=0x40, arlen=0, arid=1 -> rvalid 2 cycles later, rdata=DEADBEEF, rid=1, rlast=1, rresp=0.
- Burst read with backpressure: arlen=7 from 0x100; rready toggles 1,0,0,1,… -> 8 beats, words 0x40..0x47 in order, rlast on beat 8 only, none lost or duplicated.
- Burst write with strobes: AW 0x200, awlen=3, wstrb=4'b0011 on beat 2 -> bvalid with bid=awid and bresp=0. Readback shows bytes 3:2 of word 0x81 unchanged.
- Arbitration: arvalid and awvalid asserted together from reset -> read granted first. The next simultaneous request grants the write; neither side starves.
- Wrap and reset: ADDR_WIDTH=4, read arlen=3 from word 14 -> words 14,15,0,1. Asserting rst mid-burst -> all outputs 0 at once, IDLE after release.
- Range check (macro defined): ADDR_WIDTH=4, read at BASE_ADDR+0x40 -> rresp=2'b10, rdata=0. A write there -> no sram_we and bresp=2'b10.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// ---------------------------------------------------------------------------
// axi_slv_pkg
// Shared types and constants for the AXI SRAM responder:
//   state_t      - controller states (IDLE, RD_BURST, WR_DATA, WR_RESP)
//   RESP_*       - AXI response codes used on rresp/bresp
//   BURST_INCR   - the only burst encoding the responder implements
//   word_offset  - byte address -> 32-bit word offset relative to a base
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package axi_slv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_DATA  = 2'd2,
    WR_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Addresses below the base underflow to a large offset, which the
  // optional range check then reports as out of range.
  function automatic logic [29:0] word_offset(input logic [31:0] byte_addr,
                                              input logic [31:0] base);
    return 30'((byte_addr - base) >> 2);
  endfunction

endpackage

// File: rtl/axi_rd_skid.sv
// ---------------------------------------------------------------------------
// axi_rd_skid
// Output register plus one skid entry between the SRAM read-data return and
// the AXI r channel. The producer cannot be stalled (SRAM data appears one
// cycle after the read is issued), so the producer only issues reads when
// these two entries cannot overflow; skid_full is exported for that purpose.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_resp   returning beat from the SRAM side
//   out_valid/out_data/out_last/out_resp/out_ready   AXI r channel side
//   skid_full                 skid entry occupied
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module axi_rd_skid
  import axi_slv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_resp,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [1:0]  out_resp,
  input  logic        out_ready,
  output logic        skid_full
);

  logic [31:0] skid_data;
  logic        skid_last;
  logic [1:0]  skid_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_last  <= 1'b0;
      out_resp  <= RESP_OKAY;
      skid_full <= 1'b0;
      skid_data <= 32'd0;
      skid_last <= 1'b0;
      skid_resp <= RESP_OKAY;
    end else begin
      if (!out_valid || out_ready) begin
        // Output register free this cycle: the older skid beat goes first.
        if (skid_full) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          out_last  <= skid_last;
          out_resp  <= skid_resp;
          skid_full <= in_valid;
          if (in_valid) begin
            skid_data <= in_data;
            skid_last <= in_last;
            skid_resp <= in_resp;
          end
        end else begin
          out_valid <= in_valid;
          if (in_valid) begin
            out_data <= in_data;
            out_last <= in_last;
            out_resp <= in_resp;
          end
        end
      end else if (in_valid) begin
        // Output stalled: park the returning beat.
        skid_full <= 1'b1;
        skid_data <= in_data;
        skid_last <= in_last;
        skid_resp <= in_resp;
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI3-style responder serving INCR bursts from a single-port synchronous
// SRAM (32-bit words, 2**ADDR_WIDTH deep, read data valid one cycle after
// the read is issued). One transaction at a time; reads and writes alternate
// priority when both request in the same cycle.
// Parameters: ADDR_WIDTH (SRAM word-address width, <= 29),
//             BASE_ADDR  (byte address of SRAM word 0).
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   ar*/r*                          read address / read data channels
//   aw*/w*/b*                       write address / data / response channels
//   sram_en/sram_we/sram_addr/sram_wdata/sram_rdata   SRAM interface
// Build option: define AXI_SRAM_RANGE_CHECK_EN to answer beats outside
// [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH) with SLVERR and no SRAM write;
// otherwise addresses simply wrap modulo the SRAM depth.
// All burst types are treated as INCR and the address advances one word per
// beat regardless of arsize/awsize; narrow writes rely on wstrb.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            arid,
  input  logic [31:0]           araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [3:0]            rid,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [3:0]            awid,
  input  logic [31:0]           awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [3:0]            wid,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [3:0]            bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  state_t      state_reg, state_next;
  logic        prio_rd_reg;     // 1: read wins a simultaneous request
  logic [3:0]  id_reg;
  logic [29:0] off_reg;         // word offset from BASE_ADDR, full width
  logic [8:0]  cnt_reg;         // beats still to issue (read) / accept (write)
  logic        pend_reg;        // SRAM read in flight, data arrives next cycle
  logic        pend_last_reg;
  logic        pend_err_reg;
  logic        err_reg;         // some write beat of this burst was rejected

  logic        in_range;
  logic        ar_hs, aw_hs, w_hs, rd_issue, r_drain, rd_room;
  logic        skid_full;
  logic [1:0]  occ;
  logic        unused_ok;

`ifdef AXI_SRAM_RANGE_CHECK_EN
  assign in_range  = ((off_reg >> ADDR_WIDTH) == 30'd0);
  assign unused_ok = ^{arsize, arburst, awsize, awburst, wid, wlast};
`else
  assign in_range  = 1'b1;
  assign unused_ok = ^{arsize, arburst, awsize, awburst, wid, wlast,
                       off_reg[29:ADDR_WIDTH]};
`endif

  assign ar_hs   = arvalid & arready;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = (state_reg == WR_DATA) & wvalid;
  assign r_drain = rvalid & rready;

  // Entries that will be occupied after this edge are occ - r_drain; a read
  // issued now lands one edge later, so it needs that figure to be below 2.
  assign occ     = 2'(rvalid) + 2'(skid_full) + 2'(pend_reg);
  assign rd_room = (occ < 2'd2) || ((occ == 2'd2) && r_drain);
  assign rd_issue = (state_reg == RD_BURST) && (cnt_reg != 9'd0) && rd_room;

  always_comb begin
    state_next = state_reg;
    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    case (state_reg)
      IDLE: begin
        // Gated by rst so that every output is low while reset is held.
        arready = rst & arvalid & (~awvalid | prio_rd_reg);
        awready = rst & awvalid & (~arvalid | ~prio_rd_reg);
        if (arready)      state_next = RD_BURST;
        else if (awready) state_next = WR_DATA;
      end
      RD_BURST: begin
        sram_en = rd_issue & in_range;
        if (r_drain && rlast) state_next = IDLE;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          sram_en = in_range;
          sram_we = in_range ? wstrb : 4'b0000;
          if (cnt_reg == 9'd1) state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      prio_rd_reg   <= 1'b1;
      id_reg        <= 4'd0;
      off_reg       <= 30'd0;
      cnt_reg       <= 9'd0;
      pend_reg      <= 1'b0;
      pend_last_reg <= 1'b0;
      pend_err_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pend_reg      <= rd_issue;
      pend_last_reg <= (cnt_reg == 9'd1);
      pend_err_reg  <= ~in_range;
      if (ar_hs) begin
        id_reg      <= arid;
        off_reg     <= word_offset(araddr, BASE_ADDR);
        cnt_reg     <= {1'b0, arlen} + 9'd1;
        prio_rd_reg <= 1'b0;
      end else if (aw_hs) begin
        id_reg      <= awid;
        off_reg     <= word_offset(awaddr, BASE_ADDR);
        cnt_reg     <= {1'b0, awlen} + 9'd1;
        prio_rd_reg <= 1'b1;
        err_reg     <= 1'b0;
      end else if (rd_issue || w_hs) begin
        off_reg <= off_reg + 30'd1;
        cnt_reg <= cnt_reg - 9'd1;
        if (w_hs && !in_range) err_reg <= 1'b1;
      end
    end
  end

  axi_rd_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pend_reg),
    .in_data   (pend_err_reg ? 32'd0 : sram_rdata),
    .in_last   (pend_last_reg),
    .in_resp   (pend_err_reg ? RESP_SLVERR : RESP_OKAY),
    .out_valid (rvalid),
    .out_data  (rdata),
    .out_last  (rlast),
    .out_resp  (rresp),
    .out_ready (rready),
    .skid_full (skid_full)
  );

  assign rid        = id_reg;
  assign bid        = id_reg;
  assign bvalid     = (state_reg == WR_RESP);
  assign bresp      = (bvalid && err_reg) ? RESP_SLVERR : RESP_OKAY;
  assign sram_addr  = off_reg[ADDR_WIDTH-1:0];
  assign sram_wdata = wdata;

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Directed bench for axi_sram_slave (ADDR_WIDTH=8, BASE_ADDR=0x1000_0000)
// with a behavioural SRAM whose word i starts as 0xC0DE_0000 + i, except
// word 0x10 = 0xDEADBEEF and word 0x81 = 0xAABBCCDD.
// Honours AXI_SRAM_RANGE_CHECK_EN when choosing out-of-range expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_sram_slave;

  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;  logic [31:0] araddr; logic [7:0] arlen;
  logic [2:0]  arsize; logic [1:0] arburst; logic arvalid; logic arready;
  logic [3:0]  rid;   logic [31:0] rdata;  logic [1:0] rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;  logic [31:0] awaddr; logic [7:0] awlen;
  logic [2:0]  awsize; logic [1:0] awburst; logic awvalid; logic awready;
  logic [3:0]  wid;   logic [31:0] wdata;  logic [3:0] wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;   logic [1:0] bresp;   logic bvalid, bready;
  logic        sram_en; logic [3:0] sram_we; logic [AW-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM: preloaded on the first edge, registered read.
  logic [31:0] mem [0:(1<<AW)-1];
  logic        mem_loaded = 1'b0;
  int          we_count = 0;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hC0DE_0000 + i;
      mem[8'h10] <= 32'hDEAD_BEEF;
      mem[8'h81] <= 32'hAABB_CCDD;
      mem_loaded <= 1'b1;
      sram_rdata <= 32'd0;
    end else if (sram_en) begin
      if (sram_we == 4'b0000) begin
        sram_rdata <= mem[sram_addr];
      end else begin
        we_count <= we_count + 1;
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
    end
  end

  // Collected r beats and B results.
  logic [31:0] got_data[$];
  logic        got_last[$];
  logic [1:0]  got_resp[$];
  logic [3:0]  got_id[$];
  int          stall_viol;
  logic        b_seen;
  logic [3:0]  got_bid;
  logic [1:0]  got_bresp;
  logic [31:0] w_data [0:7];
  logic [3:0]  w_strb [0:7];
  logic        w_last [0:7];

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
    int n;
    n = 0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    #1;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (!arready) begin
      errors++;
      $display("FAIL ar_handshake: arready=%0b after %0d cycles, required 1", arready, n);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
    int n;
    n = 0;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    #1;
    while (!awready && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (!awready) begin
      errors++;
      $display("FAIL aw_handshake: awready=%0b after %0d cycles, required 1", awready, n);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input int nbeats);
    int n;
    for (int k = 0; k < nbeats; k++) begin
      @(negedge clk);
      wdata = w_data[k]; wstrb = w_strb[k]; wlast = w_last[k]; wvalid = 1'b1;
      #1;
      n = 0;
      while (!wready && n < 20) begin @(negedge clk); #1; n++; end
      checks++;
      if (!wready) begin
        errors++;
        $display("FAIL w_handshake: beat %0d wready=%0b, required 1", k, wready);
      end
      @(posedge clk);
    end
    #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    @(negedge clk);
    bready = 1'b1;
    #1;
    while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
    b_seen = bvalid; got_bid = bid; got_bresp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
    $display("B: bvalid=%0b bid=%0d bresp=%0d", b_seen, got_bid, got_bresp);
  endtask

  // mode 0: rready always 1; mode 1: rready 1,0,0,1,0,0,...
  task automatic collect_r(input int nbeats, input int mode);
    int cyc;
    logic held; logic [31:0] hd; logic hl;
    got_data.delete(); got_last.delete(); got_resp.delete(); got_id.delete();
    stall_viol = 0; cyc = 0; held = 1'b0; hd = 32'd0; hl = 1'b0;
    while (got_data.size() < nbeats && cyc < 200) begin
      @(negedge clk);
      rready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      if (held && (!rvalid || rdata !== hd || rlast !== hl)) stall_viol++;
      if (rvalid && rready) begin
        got_data.push_back(rdata); got_last.push_back(rlast);
        got_resp.push_back(rresp); got_id.push_back(rid);
        $display("R: beat %0d rid=%0d rdata=%08h rresp=%0d rlast=%0b",
                 got_data.size() - 1, rid, rdata, rresp, rlast);
      end
      held = rvalid && !rready; hd = rdata; hl = rlast;
      cyc++;
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    checks++;
    if ({arready, awready, wready, rvalid, bvalid, sram_en} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ar/aw/w/r/b/en=%06b, required 000000",
               {arready, awready, wready, rvalid, bvalid, sram_en});
    end
    checks++;
    if ({sram_we, rid, bid, rresp, bresp, rlast} !== 17'd0) begin
      errors++;
      $display("FAIL reset_fields: we=%h rid=%0d bid=%0d rresp=%0d bresp=%0d rlast=%0b, required 0",
               sram_we, rid, bid, rresp, bresp, rlast);
    end
    checks++;
    if (rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: rdata=%08h, required 0", rdata);
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("RESET: released");
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    arid = 4'd1; araddr = BASE + 32'h80; arlen = 8'd0; arvalid = 1'b1;
    awid = 4'd2; awaddr = BASE + 32'hC0; awlen = 8'd0; awvalid = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      errors++;
      $display("FAIL arb_first: arready=%0b awready=%0b, required 1/0", arready, awready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    collect_r(1, 0);
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 32'hC0DE_0020) begin
      errors++;
      $display("FAIL arb_read1: beats=%0d data=%08h, required 1 beat C0DE0020",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'd0);
    end
    arvalid = 1'b1;
    #1;
    checks++;
    if (awready !== 1'b1 || arready !== 1'b0) begin
      errors++;
      $display("FAIL arb_second: awready=%0b arready=%0b, required 1/0", awready, arready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    w_data[0] = 32'h5555_AAAA; w_strb[0] = 4'hF; w_last[0] = 1'b1;
    send_w(1);
    wait_b();
    checks++;
    if (!b_seen || got_bid !== 4'd2 || got_bresp !== 2'b00) begin
      errors++;
      $display("FAIL arb_b1: bvalid=%0b bid=%0d bresp=%0d, required 1/2/0", b_seen, got_bid, got_bresp);
    end
    awid = 4'd3; awaddr = BASE + 32'hC4; awvalid = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b1 || awready !== 1'b0) begin
      errors++;
      $display("FAIL arb_third: arready=%0b awready=%0b, required 1/0", arready, awready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    collect_r(1, 0);
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 32'hC0DE_0020 || got_id[0] !== 4'd1) begin
      errors++;
      $display("FAIL arb_read2: beats=%0d, required 1 beat C0DE0020 rid 1", got_data.size());
    end
    #1;
    checks++;
    if (awready !== 1'b1) begin
      errors++;
      $display("FAIL arb_write2_grant: awready=%0b, required 1", awready);
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    w_data[0] = 32'h6666_6666;
    send_w(1);
    wait_b();
    checks++;
    if (!b_seen || got_bid !== 4'd3 || mem[8'h30] !== 32'h5555_AAAA || mem[8'h31] !== 32'h6666_6666) begin
      errors++;
      $display("FAIL arb_writes: bid=%0d mem30=%08h mem31=%08h, required 3/5555AAAA/66666666",
               got_bid, mem[8'h30], mem[8'h31]);
    end
  endtask

  task automatic test_single_read();
    int n;
    send_ar(4'd1, BASE + 32'h40, 8'd0);
    n = 0;
    while (!rvalid && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL single_latency: rvalid after %0d cycles, required 2", n);
    end
    checks++;
    if (rdata !== 32'hDEAD_BEEF || rid !== 4'd1 || rlast !== 1'b1 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL single_beat: rdata=%08h rid=%0d rlast=%0b rresp=%0d, required DEADBEEF/1/1/0",
               rdata, rid, rlast, rresp);
    end
    collect_r(1, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_no_extra: rvalid=%0b, required 0", rvalid);
    end
  endtask

  task automatic test_burst_read_backpressure();
    send_ar(4'd3, BASE + 32'h100, 8'd7);
    collect_r(8, 1);
    checks++;
    if (got_data.size() != 8) begin
      errors++;
      $display("FAIL burst_count: beats=%0d, required 8", got_data.size());
    end
    for (int k = 0; k < 8 && k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== 32'hC0DE_0040 + k || got_last[k] !== (k == 7) || got_id[k] !== 4'd3) begin
        errors++;
        $display("FAIL burst_beat%0d: data=%08h last=%0b rid=%0d, required %08h/%0b/3",
                 k, got_data[k], got_last[k], got_id[k], 32'hC0DE_0040 + k, (k == 7));
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL burst_stall_stable: violations=%0d, required 0", stall_viol);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL burst_no_extra: rvalid=%0b, required 0", rvalid);
    end
  endtask

  task automatic test_burst_write_strobes();
    logic [31:0] exp_rb [0:3];
    @(negedge clk);
    wdata = 32'h1111_1111; wstrb = 4'hF; wvalid = 1'b1;
    #1;
    checks++;
    if (wready !== 1'b0) begin
      errors++;
      $display("FAIL w_before_aw: wready=%0b, required 0", wready);
    end
    send_aw(4'd5, BASE + 32'h200, 8'd3);
    w_data[0] = 32'h1111_1111; w_strb[0] = 4'hF;    w_last[0] = 1'b0;
    w_data[1] = 32'h2222_3344; w_strb[1] = 4'b0011; w_last[1] = 1'b0;
    w_data[2] = 32'h3333_3333; w_strb[2] = 4'hF;    w_last[2] = 1'b0;
    w_data[3] = 32'h4444_4444; w_strb[3] = 4'hF;    w_last[3] = 1'b1;
    send_w(4);
    wait_b();
    checks++;
    if (!b_seen || got_bid !== 4'd5 || got_bresp !== 2'b00) begin
      errors++;
      $display("FAIL wr_bresp: bvalid=%0b bid=%0d bresp=%0d, required 1/5/0", b_seen, got_bid, got_bresp);
    end
    send_ar(4'd6, BASE + 32'h200, 8'd3);
    collect_r(4, 0);
    exp_rb[0] = 32'h1111_1111; exp_rb[1] = 32'hAABB_3344;
    exp_rb[2] = 32'h3333_3333; exp_rb[3] = 32'h4444_4444;
    checks++;
    if (got_data.size() != 4) begin
      errors++;
      $display("FAIL wr_readback_count: beats=%0d, required 4", got_data.size());
    end
    for (int k = 0; k < 4 && k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== exp_rb[k]) begin
        errors++;
        $display("FAIL wr_readback%0d: data=%08h, required %08h", k, got_data[k], exp_rb[k]);
      end
    end
    // Early wlast must not shorten a 2-beat burst.
    send_aw(4'd7, BASE + 32'h240, 8'd1);
    w_data[0] = 32'h9090_9090; w_strb[0] = 4'hF; w_last[0] = 1'b1;
    w_data[1] = 32'h9191_9191; w_strb[1] = 4'hF; w_last[1] = 1'b1;
    send_w(2);
    wait_b();
    checks++;
    if (!b_seen || got_bid !== 4'd7 || mem[8'h90] !== 32'h9090_9090 || mem[8'h91] !== 32'h9191_9191) begin
      errors++;
      $display("FAIL wr_early_wlast: bvalid=%0b bid=%0d mem90=%08h mem91=%08h, required 1/7/90909090/91919191",
               b_seen, got_bid, mem[8'h90], mem[8'h91]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [0:3];
    exp_w[0] = 32'hC0DE_00FE; exp_w[1] = 32'hC0DE_00FF;
    exp_w[2] = 32'hC0DE_0000; exp_w[3] = 32'hC0DE_0001;
    send_ar(4'd7, BASE + 32'h3F8, 8'd3);
    collect_r(4, 0);
    checks++;
    if (got_data.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: beats=%0d, required 4", got_data.size());
    end
    for (int k = 0; k < 4 && k < got_data.size(); k++) begin
      checks++;
      if (got_data[k] !== exp_w[k]) begin
        errors++;
        $display("FAIL wrap_beat%0d: data=%08h, required %08h", k, got_data[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    send_ar(4'd2, BASE + 32'h100, 8'd7);
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: rvalid=%0b, required 1", rvalid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({rvalid, rlast, rid, rresp, sram_en, arready} !== 10'd0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL midrst_outputs: rvalid=%0b rlast=%0b rid=%0d rdata=%08h sram_en=%0b, required all 0",
               rvalid, rlast, rid, rdata, sram_en);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    $display("RESET: released after mid-burst reset");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_dropped: rvalid=%0b, required 0", rvalid);
    end
    @(negedge clk);
    arid = 4'd9; araddr = BASE + 32'h40; arlen = 8'd0; arvalid = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: arready=%0b, required 1", arready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    collect_r(1, 0);
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 32'hDEAD_BEEF || got_id[0] !== 4'd9) begin
      errors++;
      $display("FAIL midrst_after: beats=%0d, required 1 beat DEADBEEF rid 9", got_data.size());
    end
  endtask

  task automatic test_range();
    int we_before;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
`ifdef AXI_SRAM_RANGE_CHECK_EN
    exp_data = 32'd0;           exp_resp = 2'b10;
`else
    exp_data = 32'hC0DE_0000;   exp_resp = 2'b00;
`endif
    send_ar(4'd4, BASE + 32'h400, 8'd0);
    collect_r(1, 0);
    checks++;
    if (got_data.size() != 1 || got_data[0] !== exp_data || got_resp[0] !== exp_resp) begin
      errors++;
      $display("FAIL range_read: beats=%0d, required 1 beat data %08h rresp %0d",
               got_data.size(), exp_data, exp_resp);
    end
    we_before = we_count;
    send_aw(4'd8, BASE + 32'h400, 8'd0);
    w_data[0] = 32'hFEED_FACE; w_strb[0] = 4'hF; w_last[0] = 1'b1;
    send_w(1);
    wait_b();
    checks++;
    if (!b_seen || got_bresp !== exp_resp || got_bid !== 4'd8) begin
      errors++;
      $display("FAIL range_bresp: bvalid=%0b bid=%0d bresp=%0d, required 1/8/%0d",
               b_seen, got_bid, got_bresp, exp_resp);
    end
`ifdef AXI_SRAM_RANGE_CHECK_EN
    checks++;
    if (we_count != we_before || mem[0] !== 32'hC0DE_0000) begin
      errors++;
      $display("FAIL range_no_write: writes=%0d mem0=%08h, required 0/C0DE0000",
               we_count - we_before, mem[0]);
    end
`else
    checks++;
    if (we_count != we_before + 1 || mem[0] !== 32'hFEED_FACE) begin
      errors++;
      $display("FAIL range_wrap_write: writes=%0d mem0=%08h, required 1/FEEDFACE",
               we_count - we_before, mem[0]);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
    rready = 0; bready = 0;
    repeat (3) @(posedge clk);
    test_reset();
    test_arbitration();
    test_single_read();
    test_burst_read_backpressure();
    test_burst_write_strobes();
    test_wrap();
    test_reset_mid_burst();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
